// File: rtl/cla_pipe_adder16_pkg.sv
// Shared constants and the pipeline stage record for the 16-bit pipelined CLA adder.
package cla_pipe_adder16_pkg;

  localparam int unsigned SLICE_W    = 4;
  localparam int unsigned NSLICE_DEF = 4;
  localparam int unsigned DATA_W     = SLICE_W * NSLICE_DEF;

  // One pipeline stage: partial sum nibbles produced so far, carry out of the
  // highest finished nibble, and the operands whose upper nibbles are still pending.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] psum;
    logic              carry;
    logic [DATA_W-1:0] a_rem;
    logic [DATA_W-1:0] b_rem;
  } stage_t;

endpackage

// File: rtl/cla_pipe_adder16_if.sv
// Operand/result handshake bundle for cla_pipe_adder16.
interface cla_pipe_adder16_if;

  logic                                     in_valid;
  logic                                     in_ready;
  logic [cla_pipe_adder16_pkg::DATA_W-1:0]  a;
  logic [cla_pipe_adder16_pkg::DATA_W-1:0]  b;
  logic                                     cin;
  logic                                     out_valid;
  logic                                     out_ready;
  logic [cla_pipe_adder16_pkg::DATA_W-1:0]  sum;
  logic                                     cout;
  logic                                     ovf;

  // Producer/consumer side: drives operands and accepts results.
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/cla_pipe_adder16_slice.sv
// Purely combinational 4-bit carry-lookahead slice.
module cla_pipe_adder16_slice
  import cla_pipe_adder16_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               c_i,
  output logic [SLICE_W-1:0] s_o,
  output logic               c3_o,
  output logic               c4_o
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Lookahead carries, each flattened directly from c_i.
  always_comb begin
    c[0] = c_i;
    c[1] = g[0] | (p[0] & c_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_i);
  end

  assign s_o  = p ^ c[SLICE_W-1:0];
  assign c3_o = c[3];
  assign c4_o = c[4];

endmodule

// File: rtl/cla_pipe_adder16.sv
// Pipelined 16-bit adder: one CLA slice and one register stage per nibble,
// valid/ready on both sides with a single global advance.
module cla_pipe_adder16
  import cla_pipe_adder16_pkg::*;
#(
  parameter int unsigned NSLICE = NSLICE_DEF
)
(
  input  logic               clk,
  input  logic               rst,
  cla_pipe_adder16_if.slave  bus
);

  stage_t             st_q [NSLICE];
  stage_t             st_d [NSLICE];
  logic               ovf_q;
  logic               ovf_d;
  logic               adv;
  logic [SLICE_W-1:0] sl_a [NSLICE];
  logic [SLICE_W-1:0] sl_b [NSLICE];
  logic [SLICE_W-1:0] sl_s [NSLICE];
  logic [NSLICE-1:0]  sl_ci;
  logic [NSLICE-1:0]  sl_c3;
  logic [NSLICE-1:0]  sl_co;
  logic               unused_tail;

  assign adv = !st_q[NSLICE-1].valid || bus.out_ready;

  assign bus.in_ready  = adv;
  assign bus.out_valid = st_q[NSLICE-1].valid;
  assign bus.sum       = st_q[NSLICE-1].psum;
  assign bus.cout      = st_q[NSLICE-1].carry;
  assign bus.ovf       = ovf_q;

  // Last stage has no consumer for its operand copies; only carry-in-to-MSB of
  // the final slice matters.
  assign unused_tail = ^{st_q[NSLICE-1].a_rem, st_q[NSLICE-1].b_rem, sl_c3};

  for (genvar k = 0; k < NSLICE; k++) begin : g_slice
    if (k == 0) begin : g_head
      assign sl_a[k]  = bus.a[SLICE_W-1:0];
      assign sl_b[k]  = bus.b[SLICE_W-1:0];
      assign sl_ci[k] = bus.cin;
    end else begin : g_body
      assign sl_a[k]  = st_q[k-1].a_rem[SLICE_W*k +: SLICE_W];
      assign sl_b[k]  = st_q[k-1].b_rem[SLICE_W*k +: SLICE_W];
      assign sl_ci[k] = st_q[k-1].carry;
    end

    cla_pipe_adder16_slice u_slice (
      .a_i  (sl_a[k]),
      .b_i  (sl_b[k]),
      .c_i  (sl_ci[k]),
      .s_o  (sl_s[k]),
      .c3_o (sl_c3[k]),
      .c4_o (sl_co[k])
    );
  end

  // Next-state of every stage: each adds its own nibble onto the record from upstream.
  always_comb begin
    // Stage 0 only loads when adv=1, and in_ready==adv, so in_valid alone is the accept.
    st_d[0]                    = '0;
    st_d[0].valid              = bus.in_valid;
    st_d[0].psum[SLICE_W-1:0]  = sl_s[0];
    st_d[0].carry              = sl_co[0];
    st_d[0].a_rem              = bus.a;
    st_d[0].b_rem              = bus.b;
    for (int unsigned k = 1; k < NSLICE; k++) begin
      st_d[k]                             = st_q[k-1];
      st_d[k].psum[SLICE_W*k +: SLICE_W]  = sl_s[k];
      st_d[k].carry                       = sl_co[k];
    end
    ovf_d = sl_c3[NSLICE-1] ^ sl_co[NSLICE-1];
  end

  // Stage registers: cleared on reset, shift together on adv, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NSLICE; k++) begin
        st_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int unsigned k = 0; k < NSLICE; k++) begin
        st_q[k] <= st_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder16.sv
// Self-checking bench for cla_pipe_adder16 with a queue-based arithmetic reference.
module tb_cla_pipe_adder16;
  import cla_pipe_adder16_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cla_pipe_adder16_if bus ();

  cla_pipe_adder16 #(.NSLICE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned npass  = 0;
  int unsigned ncheck = 0;
  logic [17:0] expq[$];
  logic        acc_in;
  logic        acc_out;
  logic        hold_pending = 1'b0;
  logic [17:0] held;

  // Reference: {ovf, cout, sum} from plain 17-bit arithmetic.
  function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci);
    logic [16:0] t;
    logic        o;
    t = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    o = (a[15] == b[15]) && (t[15] != a[15]);
    return {o, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncheck++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One cycle: drive at negedge, sample #1 later, let the posedge happen, return at negedge.
  task automatic step(input logic iv, input logic [15:0] av, input logic [15:0] bv,
                      input logic ci, input logic ordy);
    logic [17:0] obs;
    bus.in_valid  = iv;
    bus.a         = av;
    bus.b         = bv;
    bus.cin       = ci;
    bus.out_ready = ordy;
    #1;
    obs = {bus.ovf, bus.cout, bus.sum};
    if (hold_pending) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", 32'(obs), 32'(held));
    end
    if (bus.out_valid && !ordy) check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    hold_pending = bus.out_valid && !ordy;
    held         = obs;
    acc_in  = iv && bus.in_ready;
    acc_out = bus.out_valid && ordy;
    if (acc_out) begin
      check("out_has_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) check("result", 32'(obs), 32'(expq.pop_front()));
    end
    if (acc_in) expq.push_back(ref_add(av, bv, ci));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int          nout;
    int          first;
    int          last;
    int unsigned n;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic        have;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Reset mid-flight: three adds in the pipe are discarded.
    step(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b1);
    step(1'b1, 16'h3333, 16'h4444, 1'b1, 1'b1);
    step(1'b1, 16'h5555, 16'h6666, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_sum", 32'(bus.sum), 32'd0);
    check("midrst_cout", 32'(bus.cout), 32'd0);
    expq.delete();
    hold_pending = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      #1;
      check("midrst_no_result", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end

    // Single add and its latency.
    step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1);
    check("lat_c1", 32'(bus.out_valid), 32'd0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    check("lat_c2", 32'(bus.out_valid), 32'd0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    check("lat_c3", 32'(bus.out_valid), 32'd0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    check("lat_c4", 32'(bus.out_valid), 32'd1);
    check("single_sum", 32'(bus.sum), 32'h5555);
    check("single_cout", 32'(bus.cout), 32'd0);
    check("single_ovf", 32'(bus.ovf), 32'd0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

    // Full carry ripple, then signed overflow.
    step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    check("wrap_sum", 32'(bus.sum), 32'h0000);
    check("wrap_cout", 32'(bus.cout), 32'd1);
    check("wrap_ovf", 32'(bus.ovf), 32'd0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    check("ovf_valid", 32'(bus.out_valid), 32'd1);
    check("ovf_sum", 32'(bus.sum), 32'h8000);
    check("ovf_cout", 32'(bus.cout), 32'd0);
    check("ovf_ovf", 32'(bus.ovf), 32'd1);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

    // Streaming: 256 back-to-back operands must emerge as 256 consecutive results.
    n = 0; nout = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 2000 && nout < 256; cyc++) begin
      step(n < 256, 16'(n * 257), 16'((n % 16) * 4369), n[0], 1'b1);
      if (acc_in) n++;
      if (acc_out) begin
        if (nout == 0) first = cyc;
        last = cyc;
        nout++;
      end
    end
    check("stream_count", 32'(nout), 32'd256);
    check("stream_contiguous", 32'(last - first), 32'd255);

    // Backpressure window in the middle of a stream.
    n = 0; nout = 0;
    for (int cyc = 0; cyc < 200 && nout < 20; cyc++) begin
      step(n < 20, 16'(16'hF00D ^ (n * 16'd911)), 16'(n * 16'd4099), ~n[0],
           !(cyc >= 5 && cyc <= 9));
      if (acc_in) n++;
      if (acc_out) nout++;
    end
    check("bp_count", 32'(nout), 32'd20);
    check("bp_queue_empty", 32'(expq.size()), 32'd0);

    // Random traffic; a presented operand is held until accepted.
    have = 1'b0;
    ra = '0; rb = '0; rc = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!have) begin
        ra   = 16'($urandom);
        rb   = 16'($urandom);
        rc   = 1'($urandom);
        have = 1'b1;
      end
      step(($urandom_range(0, 3) != 0), ra, rb, rc, ($urandom_range(0, 3) != 0));
      if (acc_in) have = 1'b0;
    end
    for (int cyc = 0; cyc < 50 && expq.size() != 0; cyc++) begin
      step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
    end
    check("drain_empty", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder16.md
Name: cla_pipe_adder16

Overview:
- Pipelined 16-bit adder built from four chained 4-bit carry-lookahead slices, with one register stage per slice.
- Sits directly downstream of operand sources and feeds the accumulator/result bus; it is the multi-cycle consumer of the 4-bit CLA slice.
- Valid/ready handshake on both sides, single global stall.
- Throughput one add per cycle, latency NSLICE cycles.

Parameters:
NSLICE, 4, number of 4-bit CLA slices; data width is 4*NSLICE. Only 4 is verified.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair a/b/cin valid this cycle
in_ready  output  1  adder accepts operands this cycle
a  input  16  operand A, unsigned or two's complement
b  input  16  operand B
cin  input  1  carry-in to bit 0
out_valid  output  1  sum/cout/ovf valid
out_ready  input  1  downstream accepts result
sum  output  16  a+b+cin, modulo 2^16
cout  output  1  carry out of bit 15
ovf  output  1  signed overflow: carry into bit 15 XOR carry out of bit 15

Behaviour:
- Reset: one clock, sync, active-high.
  - All stage valid bits, out_valid, sum, cout, ovf and every internal data/carry register go to 0.
  - in_ready is 1 in the first cycle after reset.
  - Reset has priority over all other inputs, including mid-operation: in-flight results are discarded and never presented.
- Pipeline structure: stage k (k=0..3) holds valid_k, the partial sum nibbles 0..k, carry_k, and the skewed, not-yet-added upper nibbles of a and b.
  - Stage 0 adds a[3:0]+b[3:0]+cin.
  - Stage k adds nibble k of the skewed operands plus carry_(k-1).
  - Stage 3 register is the output: sum, cout, ovf and out_valid are driven directly from it with no combinational path from inputs.
- Global advance: adv = !out_valid | out_ready; in_ready = adv.
  - When adv=1 all stages shift by one.
  - Stage 0 loads in_valid & in_ready; bubbles propagate as valid=0.
  - When adv=0 every register holds, so outputs stay stable while out_valid=1 and out_ready=0.
- Handshake rules:
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
  - in_valid=1 with in_ready=0 does not transfer; the producer holds its values.
  - in_ready never depends combinationally on in_valid.
- Latency: an operand accepted at edge N, with no stalls, appears as out_valid=1 after edge N+3, i.e. in the 4th cycle of its flight.
  - Each cycle of out_ready=0 while out_valid=1 adds one cycle.
- Throughput: with out_ready held 1, one result per cycle; back-to-back inputs give back-to-back outputs.
- Simultaneous events: at a full pipe with out_ready=1 and in_valid=1, output and input transfer in the same cycle; no bubble is inserted.
- Arithmetic:
  - sum = (a+b+cin) mod 2^16; cout = bit 16 of the 17-bit result.
  - ovf = (a[15]==b[15]) & (sum[15]!=a[15]).
  - Wrap-around at 0xFFFF+1 yields sum=0, cout=1.
- Bubbles: stages with valid=0 still shift data, but their contents are don't-care and out_valid=0 for them.

Decomposition:
- Shared package: SLICE_W=4 constant and a stage-record typedef (valid, partial sum, carry, remaining a/b nibbles).
- Sub-module: one 4-bit CLA slice (generate/propagate, lookahead carries c1..c4, sum bits), instantiated NSLICE times, one per stage. It is purely combinational; all registers live in cla_pipe_adder16.

Test Plan:
- Reset mid-flight: issue 3 adds, assert rst for 1 cycle -> out_valid=0, sum=0, cout=0 next cycle; the 3 results never appear.
- Single add: a=16'h1234, b=16'h4321, cin=0, out_ready=1 -> out_valid after 4 cycles with sum=16'h5555, cout=0, ovf=0.
- Carry chain through all slices: a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1, ovf=0. Then a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1.
- Streaming: 256 back-to-back inputs (a=i*257, b=j*4369 swept), out_ready=1 -> 256 consecutive out_valid cycles, each sum equal to the scoreboard value, in order.
- Backpressure: stream with out_ready=0 for cycles 5..9 -> in_ready=0 while out_valid=1; sum held constant; no loss or duplication; order preserved after release.
- Random: 10k random a/b/cin with random in_valid/out_ready -> every result matches a reference {cout,sum}=a+b+cin, and ovf matches the signed check.
